// File: rtl/gray_stream_ctrl_if.sv
// Bundle of control, pixel-in, datapath and gray-out signals for gray_stream_ctrl.
// The "master" modport is the controller's view; "slave" is the surrounding system.
// Optional macro GRAY_PERF_EN adds the stall/starve performance counters.
interface gray_stream_ctrl_if #(
    parameter int CNT_W = 22
);
    logic             start;
    logic [CNT_W-1:0] num_pixels;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_data;
    logic [31:0]      cv_r;
    logic [31:0]      cv_g;
    logic [31:0]      cv_b;
    logic [31:0]      cv_result;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
`ifdef GRAY_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      starve_cycles;
`endif

    modport master (
        input  start, num_pixels, in_valid, in_data, cv_result, out_ready,
        output busy, done, in_ready, cv_r, cv_g, cv_b, out_valid, out_data, out_last
`ifdef GRAY_PERF_EN
        , output stall_cycles, starve_cycles
`endif
    );

    modport slave (
        output start, num_pixels, in_valid, in_data, cv_result, out_ready,
        input  busy, done, in_ready, cv_r, cv_g, cv_b, out_valid, out_data, out_last
`ifdef GRAY_PERF_EN
        , input stall_cycles, starve_cycles
`endif
    );
endinterface

// File: rtl/gray_stream_ctrl.sv
// Frame sequencer for the RGB-to-gray datapath: one pixel stage feeding the
// external combinational converter, a small output FIFO and a backpressured
// 8-bit gray stream. Optional macro GRAY_PERF_EN adds stall/starve counters.
module gray_stream_ctrl #(
    parameter int CNT_W     = 22,
    parameter int OUT_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    gray_stream_ctrl_if.master bus
);
    localparam int              PTR_W    = $clog2(OUT_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(OUT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic [7:0]       s1_r_q, s1_r_d;
    logic [7:0]       s1_g_q, s1_g_d;
    logic [7:0]       s1_b_q, s1_b_d;

    logic [7:0]       buf_data_q [OUT_DEPTH];
    logic             buf_last_q [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic             buf_full, buf_empty, pop, s1_adv, accept, in_ready_c, last_pix;
    logic [7:0]       sat_res;

    assign buf_full   = (count_q == FULL_CNT);
    assign buf_empty  = (count_q == '0);
    assign pop        = !buf_empty && bus.out_ready;
    assign s1_adv     = s1_valid_q && (!buf_full || pop);
    assign in_ready_c = (state_q == RUN) && (acc_cnt_q < len_q) && (!s1_valid_q || s1_adv);
    assign accept     = bus.in_valid && in_ready_c;
    assign last_pix   = (acc_cnt_q == len_q - CNT_W'(1));
    assign sat_res    = (bus.cv_result > 32'd255) ? 8'hFF : bus.cv_result[7:0];

    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.in_ready  = in_ready_c;
    assign bus.cv_r      = {24'd0, s1_r_q};
    assign bus.cv_g      = {24'd0, s1_g_q};
    assign bus.cv_b      = {24'd0, s1_b_q};
    assign bus.out_valid = !buf_empty;
    assign bus.out_data  = buf_data_q[rd_ptr_q];
    assign bus.out_last  = buf_last_q[rd_ptr_q];

    // Frame sequencing: latch length on start, count accepts and pops, pick next state
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        out_cnt_d = out_cnt_q;
        if (pop) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d     = bus.num_pixels;
                    acc_cnt_d = '0;
                    out_cnt_d = '0;
                    if (bus.num_pixels == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (last_pix) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_cnt_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixel stage: empties when its result moves to the FIFO, reloads on accept in the same cycle
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_r_d     = bus.in_data[23:16];
            s1_g_d     = bus.in_data[15:8];
            s1_b_d     = bus.in_data[7:0];
            s1_last_d  = last_pix;
        end
    end

    // Control and stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            out_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_cnt_q  <= acc_cnt_d;
            out_cnt_q  <= out_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
        end
    end

    // Output FIFO: power-of-two depth so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (s1_adv) begin
                buf_data_q[wr_ptr_q] <= sat_res;
                buf_last_q[wr_ptr_q] <= s1_last_q;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({s1_adv, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef GRAY_PERF_EN
    logic [31:0] stall_q, starve_q;

    // Saturating stall/starve counters, cleared when a new frame is started
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            if (bus.busy && !buf_empty && !bus.out_ready && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (state_q == RUN && acc_cnt_q < len_q && !bus.in_valid && starve_q != '1) begin
                starve_q <= starve_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles  = stall_q;
    assign bus.starve_cycles = starve_q;
`else
    // Performance counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Scoreboard bench for gray_stream_ctrl: a source queue feeds pixels, each accepted
// pixel pushes its expected gray sample, and an output monitor pops and compares.
`timescale 1ns/1ps
module tb_gray_stream_ctrl;
    localparam int CNT_W     = 22;
    localparam int OUT_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gray_stream_ctrl_if #(.CNT_W(CNT_W)) bus ();

    gray_stream_ctrl #(.CNT_W(CNT_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int bias;

    // External conversion datapath, with an adjustable offset to reach saturation
    assign bus.cv_result = (bus.cv_r * 32'd299 + bus.cv_g * 32'd587 + bus.cv_b * 32'd114) / 32'd1000
                           + 32'(bias);

    int          errors, checks, cyc;
    logic [23:0] srcQ[$];
    logic [8:0]  expQ[$];
    int          curLen, accCnt, popCnt, doneCount, startDone;
    bit          active, doneFlag, monOn, pauseIn, inReadyLowSeen, outValidSeen, orManual;
    int          gapPct, orMode;
    int          firstAccCyc, firstValCyc, startCyc, doneCyc;
    logic [31:0] refStall, refStarve;

    function automatic int refGray(input logic [23:0] p);
        int v;
        v = (int'(p[23:16]) * 299 + int'(p[15:8]) * 587 + int'(p[7:0]) * 114) / 1000 + bias;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int len);
        bus.start      = 1'b1;
        bus.num_pixels = CNT_W'(len);
        curLen         = len;
        accCnt         = 0;
        popCnt         = 0;
        doneFlag       = 1'b0;
        firstAccCyc    = -1;
        firstValCyc    = -1;
        outValidSeen   = 1'b0;
        inReadyLowSeen = 1'b0;
        refStall       = '0;
        refStarve      = '0;
        startDone      = doneCount;
        tick();
        bus.start = 1'b0;
        active    = 1'b1;
        startCyc  = cyc;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstBusy", 32'(bus.busy), 0);
        checkOutput("rstDone", 32'(bus.done), 0);
        checkOutput("rstInReady", 32'(bus.in_ready), 0);
        checkOutput("rstOutValid", 32'(bus.out_valid), 0);
        checkOutput("rstOutData", 32'(bus.out_data), 0);
        checkOutput("rstOutLast", 32'(bus.out_last), 0);
        checkOutput("rstCvR", bus.cv_r, 0);
        checkOutput("rstCvG", bus.cv_g, 0);
        checkOutput("rstCvB", bus.cv_b, 0);
`ifdef GRAY_PERF_EN
        checkOutput("rstStall", bus.stall_cycles, 0);
        checkOutput("rstStarve", bus.starve_cycles, 0);
`endif
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        srcQ.delete();
        expQ.delete();
        active = 1'b0;
        accCnt = 0;
        curLen = 0;
    endtask

    task automatic waitFrame(input int bound);
        int n;
        n = 0;
        while (!doneFlag && n < bound) begin
            tick();
            n++;
        end
        tick();
        checkOutput("frameDone", 32'(doneFlag), 1);
        if (doneFlag) begin
            checkOutput("accepted", 32'(accCnt), 32'(curLen));
            checkOutput("popped", 32'(popCnt), 32'(curLen));
            checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);
            checkOutput("donePulses", 32'(doneCount - startDone), 1);
            checkOutput("busyAfterDone", 32'(bus.busy), 0);
`ifdef GRAY_PERF_EN
            checkOutput("stallCycles", bus.stall_cycles, refStall);
            checkOutput("starveCycles", bus.starve_cycles, refStarve);
`endif
        end else begin
            doReset();
        end
    endtask

    // Input and out_ready drivers, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (srcQ.size() > 0 && !pauseIn && ($urandom_range(99) >= 32'(gapPct))) begin
                bus.in_valid = 1'b1;
                bus.in_data  = srcQ[0];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 24'($urandom);
            end
            case (orMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = orManual;
            endcase
        end
    end

    // Monitor: reference busy/perf model, accept capture and output scoreboard
    always @(negedge clk) begin
        logic [23:0] p;
        logic [8:0]  e;
        logic [7:0]  g8;
        int          g;
        bit          modelBusy;
        cyc++;
        if (monOn && !rst) begin
            modelBusy = active && !bus.done;
            checkOutput("busy", 32'(bus.busy), 32'(modelBusy));
            if (modelBusy && bus.out_valid && !bus.out_ready) refStall++;
            if (modelBusy && accCnt < curLen && !bus.in_valid) refStarve++;
            if (bus.in_ready) checkOutput("inReadyOnlyWhileFilling", 32'(modelBusy && accCnt < curLen), 1);
            if (modelBusy && accCnt < curLen && bus.in_valid && !bus.in_ready) inReadyLowSeen = 1'b1;
            if (bus.in_valid && bus.in_ready && srcQ.size() > 0) begin
                p  = srcQ.pop_front();
                g  = refGray(p);
                g8 = g[7:0];
                expQ.push_back({(accCnt == curLen - 1), g8});
                if (accCnt == 0) firstAccCyc = cyc;
                accCnt++;
            end
            if (bus.out_valid) begin
                checkOutput("outValidWhileBusy", 32'(modelBusy), 1);
                outValidSeen = 1'b1;
                if (firstValCyc < 0) firstValCyc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedSample actual=%0d required=none", bus.out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outData", 32'(bus.out_data), 32'(e[7:0]));
                    checkOutput("outLast", 32'(bus.out_last), 32'(e[8]));
                end
                popCnt++;
            end
            if (bus.done) begin
                checkOutput("doneWhileActive", 32'(active), 1);
                doneCount++;
                doneFlag = 1'b1;
                doneCyc  = cyc;
                active   = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        errors = 0; checks = 0; cyc = 0; doneCount = 0;
        bias = 0; gapPct = 0; orMode = 0; orManual = 1'b1;
        monOn = 1'b0; pauseIn = 1'b0; active = 1'b0; curLen = 0; accCnt = 0;
        bus.start = 1'b0; bus.num_pixels = '0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        checkResetOutputs();
        rst   = 1'b0;
        monOn = 1'b1;

        $display("[TB] directed frame of five primaries");
        srcQ = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h808080};
        applyStimulus(5);
        waitFrame(200);
        checkOutput("firstSampleLatency", 32'(firstValCyc - firstAccCyc), 2);

        $display("[TB] zero-length frame");
        applyStimulus(0);
        waitFrame(20);
        checkOutput("zeroNoOutValid", 32'(outValidSeen), 0);
        checkOutput("zeroDonePrompt", 32'((doneCyc - startCyc) >= 1 && (doneCyc - startCyc) <= 2), 1);

        $display("[TB] toggling out_ready");
        orMode = 1;
        for (int i = 0; i < 8; i++) srcQ.push_back(24'($urandom));
        applyStimulus(8);
        waitFrame(300);
        checkOutput("inReadyBackpressure", 32'(inReadyLowSeen), 1);

        $display("[TB] excess input carried to next frame");
        orMode = 0;
        for (int i = 0; i < 5; i++) srcQ.push_back(24'($urandom));
        applyStimulus(3);
        waitFrame(200);
        checkOutput("leftoverPixels", 32'(srcQ.size()), 2);
        applyStimulus(2);
        waitFrame(200);
        checkOutput("leftoverConsumed", 32'(srcQ.size()), 0);

        $display("[TB] reset mid-frame");
        srcQ = '{24'h123456, 24'h654321};
        applyStimulus(6);
        n = 0;
        while (accCnt < 2 && n < 50) begin tick(); n++; end
        checkOutput("midFrameAccepts", 32'(accCnt), 2);
        startDone = doneCount;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        srcQ.delete(); expQ.delete();
        active = 1'b0; accCnt = 0; curLen = 0;
        checkResetOutputs();
        repeat (5) tick();
        checkOutput("noDoneAfterAbort", 32'(doneCount - startDone), 0);
        srcQ.push_back(24'h808080);
        applyStimulus(1);
        waitFrame(100);

`ifdef GRAY_PERF_EN
        $display("[TB] performance counters");
        orMode = 3; orManual = 1'b1;
        srcQ = '{24'h102030, 24'h405060};
        applyStimulus(4);
        n = 0;
        while (accCnt < 2 && n < 50) begin tick(); n++; end
        tick();
        srcQ.push_back(24'h708090);
        srcQ.push_back(24'hA0B0C0);
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        orManual = 1'b0;
        repeat (3) tick();
        orManual = 1'b1;
        waitFrame(200);
`endif

        $display("[TB] randomized frames");
        orMode = 2;
        for (int f = 0; f < 10; f++) begin
            int len;
            len    = 32'($urandom_range(1, 12));
            bias   = (f % 3 == 2) ? 32'($urandom_range(50, 200)) : 0;
            gapPct = 32'($urandom_range(0, 40));
            for (int i = 0; i < len; i++) srcQ.push_back(24'($urandom));
            applyStimulus(len);
            waitFrame(2000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
